// File: rtl/pll_rst_pkg.sv
// Shared types and default constants for the PLL lock / core reset sequencer.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_CE_DIV        = 4;
    localparam int DEF_CNT_W         = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer, async reset to 0.
module sync_bit
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Turns the PLL 'locked' flag into a debounced, sequenced core reset and a
// pixel clock-enable; counts lock losses seen while the core was running.
module pll_lock_reset_seq
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int CE_DIV        = DEF_CE_DIV,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             soft_reset,
    output logic             core_reset,
    output logic             ce_pix,
    output logic             run,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_BITS = $clog2(max_int(STABLE_CYCLES, HOLD_CYCLES));
    localparam int DIV_BITS = $clog2(CE_DIV);

    localparam logic [CNT_BITS-1:0] STABLE_LAST = CNT_BITS'(STABLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] HOLD_LAST   = CNT_BITS'(HOLD_CYCLES - 1);
    localparam logic [DIV_BITS-1:0] DIV_LAST    = DIV_BITS'(CE_DIV - 1);

    state_t              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic                locked_s;
    logic                core_reset_d, run_d, ce_pix_d, div_en;
    logic [CNT_W-1:0]    lock_loss_d;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_locked (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lock loss outranks soft_reset, which outranks count expiry.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) state_d = STABLE;
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (soft_reset) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s)       state_d = WAIT_LOCK;
                else if (soft_reset) state_d = HOLD;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they flip on the same edge as the state.
    always_comb begin
        core_reset_d = (state_d != RUN);
        run_d        = (state_d == RUN);
        div_en       = ((state_d == HOLD) || (state_d == RUN)) &&
                       !((state_d == HOLD) && (state_q != HOLD));
        ce_pix_d     = 1'b0;
        div_d        = '0;
        if (div_en) begin
            ce_pix_d = (div_q == DIV_LAST);
            div_d    = ce_pix_d ? '0 : div_q + DIV_BITS'(1);
        end
        lock_loss_d = lock_loss_cnt;
        if ((state_q == RUN) && (state_d == WAIT_LOCK) && (lock_loss_cnt != '1))
            lock_loss_d = lock_loss_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_reset    <= 1'b1;
            run           <= 1'b0;
            ce_pix        <= 1'b0;
            div_q         <= '0;
            lock_loss_cnt <= '0;
        end else begin
            core_reset    <= core_reset_d;
            run           <= run_d;
            ce_pix        <= ce_pix_d;
            div_q         <= div_d;
            lock_loss_cnt <= lock_loss_d;
        end
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench: stimulus queues expected output changes with their edge
// number; a negedge monitor pops one entry for every change the DUT shows.
module tb_pll_lock_reset_seq;

    localparam logic [10:0] RST_VEC = {1'b1, 1'b0, 1'b0, 8'd0};

    typedef struct {
        int          cyc;
        logic [10:0] vec;
        string       tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, pll_locked, soft_reset;
    logic       core_reset, ce_pix, run;
    logic [7:0] lock_loss_cnt;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          run_ref;
    logic [7:0]  exp_llc = 8'd0;
    logic [10:0] prev_vec = RST_VEC;
    exp_t        exp_q[$];

    pll_lock_reset_seq #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (8),
        .HOLD_CYCLES   (4),
        .CE_DIV        (4),
        .CNT_W         (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .soft_reset    (soft_reset),
        .core_reset    (core_reset),
        .ce_pix        (ce_pix),
        .run           (run),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [42:0] act, input logic [42:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got edge %0d out %h, expected edge %0d out %h",
                     name, act[42:11], act[10:0], expv[42:11], expv[10:0]);
        end
    endtask

    function automatic logic [10:0] outs();
        return {core_reset, run, ce_pix, lock_loss_cnt};
    endfunction

    // Monitor: one pop per observed change, overdue entries count as misses.
    always @(negedge clk) begin
        logic [10:0] cur;
        exp_t        e;
        cur = outs();
        if (rst) begin
            prev_vec = RST_VEC;
        end else begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                check({"missed ", e.tag}, {cyc, cur}, {e.cyc, e.vec});
            end
            if (cur != prev_vec) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", {cyc, cur}, {cyc, prev_vec});
                end else begin
                    e = exp_q.pop_front();
                    check(e.tag, {cyc, cur}, {e.cyc, e.vec});
                end
            end
            prev_vec = cur;
        end
    end

    task automatic exp_ev(input int c, input logic cr, input logic rn, input logic ce, input string tag);
        exp_t e;
        e.cyc = c;
        e.vec = {cr, rn, ce, exp_llc};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic lock_to_run();
        int c0 = cyc;
        exp_ev(c0 + 15, 1'b0, 1'b1, 1'b1, "lock_run_entry");
        exp_ev(c0 + 16, 1'b0, 1'b1, 1'b0, "lock_first_ce_fall");
        pll_locked = 1'b1;
        wait_until(c0 + 16);
        run_ref = c0 + 15;
    endtask

    task automatic stay_run(input int n);
        for (int m = 1; m <= n; m++) begin
            exp_ev(run_ref + 4*m,     1'b0, 1'b1, 1'b1, "ce_rise");
            exp_ev(run_ref + 4*m + 1, 1'b0, 1'b1, 1'b0, "ce_fall");
        end
        wait_until(run_ref + 4*n + 1);
    endtask

    task automatic bump_llc();
        exp_llc = (exp_llc == 8'hFF) ? 8'hFF : exp_llc + 8'd1;
    endtask

    task automatic lose_lock();
        int c = cyc;
        bump_llc();
        exp_ev(c + 3, 1'b1, 1'b0, 1'b0, "lock_loss");
        pll_locked = 1'b0;
        wait_until(c + 3);
    endtask

    task automatic glitch_lock();
        int c0 = cyc;
        exp_ev(c0 + 22, 1'b0, 1'b1, 1'b1, "glitch_run_entry");
        exp_ev(c0 + 23, 1'b0, 1'b1, 1'b0, "glitch_ce_fall");
        pll_locked = 1'b1;
        wait_until(c0 + 6);
        pll_locked = 1'b0;
        wait_until(c0 + 7);
        pll_locked = 1'b1;
        wait_until(c0 + 23);
        run_ref = c0 + 22;
    endtask

    task automatic soft_pulse();
        int c = cyc;
        exp_ev(c + 1, 1'b1, 1'b0, 1'b0, "soft_enter_hold");
        exp_ev(c + 5, 1'b0, 1'b1, 1'b1, "soft_run_reentry");
        exp_ev(c + 6, 1'b0, 1'b1, 1'b0, "soft_ce_fall");
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        wait_until(c + 6);
        run_ref = c + 5;
    endtask

    task automatic soft_and_loss();
        int c = cyc;
        bump_llc();
        exp_ev(c + 3, 1'b1, 1'b0, 1'b0, "soft_with_loss");
        pll_locked = 1'b0;
        wait_until(c + 2);
        soft_reset = 1'b1;
        wait_until(c + 3);
        soft_reset = 1'b0;
    endtask

    task automatic hold_soft_held();
        int c0 = cyc;
        for (int m = 0; m < 6; m++) begin
            exp_ev(c0 + 15 + 4*m, 1'b1, 1'b0, 1'b1, "hold_ce_rise");
            if (m < 5) exp_ev(c0 + 16 + 4*m, 1'b1, 1'b0, 1'b0, "hold_ce_fall");
        end
        exp_ev(c0 + 36, 1'b0, 1'b1, 1'b0, "run_after_soft_release");
        pll_locked = 1'b1;
        wait_until(c0 + 12);
        soft_reset = 1'b1;
        wait_until(c0 + 32);
        soft_reset = 1'b0;
        wait_until(c0 + 36);
        run_ref = c0 + 35;
    endtask

    task automatic async_reset(input string name);
        #2 rst = 1'b1;
        #1 check(name, {32'd0, outs()}, {32'd0, RST_VEC});
        exp_llc = 8'd0;
        @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst = 1'b1;
        pll_locked = 1'b0;
        soft_reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {32'd0, outs()}, {32'd0, RST_VEC});
        rst = 1'b0;

        lock_to_run();
        stay_run(2);
        lose_lock();
        glitch_lock();
        stay_run(1);
        soft_pulse();
        stay_run(1);
        soft_and_loss();
        hold_soft_held();
        stay_run(1);

        for (int i = 0; i < 300; i++) begin
            lose_lock();
            lock_to_run();
            stay_run(1);
        end
        check("saturated_run", {32'd0, outs()}, {32'd0, 1'b0, 1'b1, 1'b0, 8'hFF});
        async_reset("async_rst_mid_run");

        c0 = cyc;
        pll_locked = 1'b1;
        wait_until(c0 + 13);
        async_reset("async_rst_mid_hold");

        lock_to_run();
        stay_run(1);
        lose_lock();
        repeat (8) @(negedge clk);
        check("queue_drained", 43'(exp_q.size()), 43'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
